// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pops synchronous_fifo words through a 2-entry credit-managed skid buffer
// and emits them as a valid/ready stream with burst framing. Optional statistics: STREAM_RD_STATS_EN.
module fifo_stream_reader #(
  parameter int G_WIDTH     = 8,
  parameter int G_BURST_LEN = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  output logic               o_fifo_rd,
  input  logic               i_fifo_empty,
  input  logic [G_WIDTH-1:0] i_fifo_data,
  input  logic               i_fifo_rd_done,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [G_WIDTH-1:0] o_data,
  output logic               o_last,
  output logic               o_protocol_err,
  output logic [31:0]        o_word_cnt,
  output logic [31:0]        o_stall_cnt
);

  localparam int BCNT_W = (G_BURST_LEN > 1) ? $clog2(G_BURST_LEN) : 1;
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(G_BURST_LEN - 1);

  logic [1:0]         occ;
  logic               infl;
  logic [BCNT_W-1:0]  bcnt;
  logic [G_WIDTH-1:0] skid_q0;
  logic [G_WIDTH-1:0] skid_q1;
  logic               prot_err;
  logic               xfer;
  logic               push;
  logic [2:0]         credit;

  // Credits count both buffered words and the read still in flight, so a read is only
  // issued when its data is guaranteed a slot. Reads are suppressed while in reset.
  always_comb begin
    o_valid   = (occ != 2'd0);
    xfer      = o_valid & i_ready;
    push      = i_fifo_rd_done & infl;
    credit    = {1'b0, occ} + {2'b00, infl};
    o_fifo_rd = i_rst_n & i_en & ~i_fifo_empty & (credit < (3'd2 + {2'b00, xfer}));
    o_data    = skid_q0;
    o_last    = o_valid & (bcnt == BCNT_MAX);
    o_protocol_err = prot_err;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      occ      <= 2'd0;
      infl     <= 1'b0;
      bcnt     <= '0;
      skid_q0  <= '0;
      skid_q1  <= '0;
      prot_err <= 1'b0;
    end else begin
      infl <= o_fifo_rd;
      occ  <= occ + {1'b0, push} - {1'b0, xfer};
      if (i_fifo_rd_done && !infl)
        prot_err <= 1'b1;
      // Head is skid_q0; pop shifts skid_q1 forward, or takes the arriving word directly
      if (xfer) begin
        if (occ == 2'd2)
          skid_q0 <= skid_q1;
        else if (push)
          skid_q0 <= i_fifo_data;
      end else if (push) begin
        if (occ == 2'd0)
          skid_q0 <= i_fifo_data;
        else
          skid_q1 <= i_fifo_data;
      end
      if (xfer)
        bcnt <= o_last ? '0 : bcnt + BCNT_W'(1);
    end
  end

`ifdef STREAM_RD_STATS_EN
  logic [31:0] word_cnt;
  logic [31:0] stall_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer)
        word_cnt <= sat_inc(word_cnt);
      if (o_valid && !i_ready)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign o_word_cnt  = word_cnt;
  assign o_stall_cnt = stall_cnt;
`else
  assign o_word_cnt  = 32'd0;
  assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side adapter for synchronous_fifo. It pops words through the FIFO read port (i_rd / o_data / f_rd_done, with data returned one cycle after the read) and presents them as a valid/ready stream to a downstream consumer. A 2-entry skid buffer with credit accounting sustains one word per clock and never issues a read to an empty FIFO. Output words are grouped into fixed-length bursts, and each burst is marked with last.

Parameters:
G_WIDTH, 8, data word width; must match the FIFO G_WIDTH.
G_BURST_LEN, 4, words per burst; o_last is asserted on every G_BURST_LEN-th word; legal range 1..65535.

Ports:
i_clk  in  1  single clock, shared with the FIFO read domain.
i_rst_n  in  1  synchronous reset, active-low.
i_en  in  1  read enable; while low, no new FIFO reads are issued and buffered words still drain.
o_fifo_rd  out  1  FIFO read request; drives the FIFO i_rd.
i_fifo_empty  in  1  FIFO o_empty.
i_fifo_data  in  G_WIDTH  FIFO o_data; valid in the cycle i_fifo_rd_done=1.
i_fifo_rd_done  in  1  FIFO f_rd_done; one-cycle pulse one clock after an accepted read.
o_valid  out  1  stream word valid.
i_ready  in  1  downstream ready.
o_data  out  G_WIDTH  stream data.
o_last  out  1  last word of the current burst.
o_protocol_err  out  1  sticky; set when i_fifo_rd_done arrives with no read in flight.
o_word_cnt  out  32  words transferred (optional feature).
o_stall_cnt  out  32  backpressure cycles (optional feature).

Behaviour:
- Reset (i_rst_n=0 at a rising edge): the following are all cleared to 0:
  - skid occupancy, in-flight flag, burst counter
  - o_valid, o_data, o_fifo_rd, o_last, o_protocol_err
  - both statistic counters
  A rd_done arriving in the reset cycle is discarded. The FIFO read domain is reset in the same cycle by system integration.
- State:
  - occ: 0..2, number of words in the skid buffer.
  - infl: 0..1, read issued but data not yet returned.
  - bcnt: 0..G_BURST_LEN-1, width clog2(G_BURST_LEN), minimum 1 bit.
- Handshake: a transfer occurs in a cycle where o_valid=1 and i_ready=1.
- o_valid equals (occ != 0). o_data and o_last show the oldest buffered entry.
- While o_valid=1 and i_ready=0, o_data and o_last hold stable.
- Read issue (combinational):
  - o_fifo_rd = i_en && !i_fifo_empty && (occ + infl - xfer) < 2, where xfer = o_valid && i_ready.
  - The path from i_ready to o_fifo_rd is combinational by design.
  - o_fifo_rd is never asserted while i_fifo_empty=1, so the FIFO underflow flag is never raised by this block.
- Update each cycle:
  - infl_next = o_fifo_rd.
  - When i_fifo_rd_done=1, i_fifo_data is written into the buffer tail.
  - occ_next = occ + rd_done - xfer.
  - A simultaneous push and pop at occ=2 cannot occur because of the credit rule.
- Latency: a word present in a non-empty FIFO with an idle buffer and i_ready=1 appears on o_valid 2 cycles after o_fifo_rd is asserted. Throughput is 1 word per clock at steady state.
- Burst counter:
  - o_last = (bcnt == G_BURST_LEN-1).
  - On a transfer, bcnt wraps to 0 if o_last=1, otherwise it increments.
  - With G_BURST_LEN=1, o_last is 1 whenever o_valid=1.
- Protocol error: i_fifo_rd_done=1 while infl=0 sets o_protocol_err, which is sticky until reset. The data is dropped and occ is unchanged.
- i_en deasserted mid-stream: an in-flight word is still captured and drained. The burst counter is not reset.
- FIFO going empty mid-burst: o_valid drops once the buffer drains. bcnt is preserved, and the burst resumes when data returns.

Optional Feature:
STREAM_RD_STATS_EN
- Defined:
  - o_word_cnt increments on every transfer.
  - o_stall_cnt increments on every cycle with o_valid=1 and i_ready=0.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Not defined: both ports remain in the interface, tied to 0, and no counter logic is synthesized.

Test Plan:
1. Reset then stream: FIFO preloaded with 0x01..0x08, i_en=1, i_ready=1 → o_fifo_rd on the first cycle after reset; first o_valid 2 cycles later; 8 consecutive transfers 0x01..0x08; o_last on 0x04 and 0x08 (G_BURST_LEN=4).
2. Backpressure: i_ready=0 for 5 cycles mid-stream → o_data stable; occ reaches 2; o_fifo_rd deasserted; no data loss or reorder; o_stall_cnt=5 with STREAM_RD_STATS_EN.
3. Empty FIFO: i_fifo_empty=1 with i_en=1 for 10 cycles → o_fifo_rd=0 and o_valid=0 throughout. Then push 0x55 → 0x55 is output with bcnt continuing from its prior value.
4. i_en drop: deassert i_en the cycle o_fifo_rd=1 → the in-flight word is still output; no further reads while i_en=0.
5. Spurious rd_done: pulse i_fifo_rd_done with no read issued → o_protocol_err=1 and stays 1; occ unchanged; cleared only by i_rst_n=0.
6. Reset mid-burst: assert i_rst_n=0 with occ=2 and bcnt=2 → next cycle o_valid=0, o_last=0, counters 0, and the next burst restarts at bcnt=0.
